npu_stream_fifo: RTL and testbench

- Parametrised register-based synchronous FIFO for NPU datapaths (weight/activation staging between memory reader and PE array).
- Generalises the basic enable/wr/rd FIFO with:
  - non-power-of-two depth;
  - selectable registered-output or first-word-fall-through (FWFT) read mode;
  - occupancy count and programmable almost-full/almost-empty flags;
  - protected over/underflow with sticky error flags;
  - synchronous flush.

---
 rtl/npu_fifo_pkg.sv | 13 +
 rtl/npu_fifo_ctrl.sv | 81 ++++++++
 rtl/npu_stream_fifo.sv | 102 ++++++++++
 tb/tb_npu_stream_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_fifo_pkg.sv
// Shared definitions for the NPU stream FIFO: read-mode encodings and the
// non-power-of-two pointer increment.
package npu_fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Wraps at depth-1 by explicit compare so any depth >= 2 works.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/npu_fifo_ctrl.sv
// FIFO control: read/write pointers, occupancy count, accept terms and all
// status flags (registered from the next count) including sticky errors.
module npu_fifo_ctrl
    import npu_fifo_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flush,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic             wr_acc,
    output logic             rd_acc,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_TH    = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AE_TH    = CNT_W'(AEMPTY_TH);
    localparam logic             AF_RST   = (AFULL_TH == 0);

    logic             op_ok;
    logic [CNT_W-1:0] cnt_nxt;

    // Flush wins over same-cycle requests, so it also masks the accept terms.
    assign op_ok  = enable & ~flush;
    assign rd_acc = op_ok & rd_en & ~empty;
    assign wr_acc = op_ok & wr_en & (~full | rd_acc);

    always_comb begin
        cnt_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_nxt = count + 1'b1;
            2'b01:   cnt_nxt = count - 1'b1;
            default: cnt_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (enable && flush)) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= AF_RST;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (enable) begin
            if (wr_acc)
                wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
            if (rd_acc)
                rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
            count        <= cnt_nxt;
            full         <= (cnt_nxt == FULL_CNT);
            empty        <= (cnt_nxt == '0);
            almost_full  <= (cnt_nxt >= AF_TH);
            almost_empty <= (cnt_nxt <= AE_TH);
            if (wr_en && full && !rd_acc)
                overflow <= 1'b1;
            if (rd_en && empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/npu_stream_fifo.sv
// Register-based stream FIFO for NPU weight/activation staging with
// registered or first-word-fall-through read port.
module npu_stream_fifo
    import npu_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             wr_acc;
    logic             rd_acc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    npu_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH),
        .AEMPTY_TH(AEMPTY_TH),
        .PTR_W    (PTR_W),
        .CNT_W    (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .flush       (flush),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_acc      (wr_acc),
        .rd_acc      (rd_acc),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Storage is never reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Empty presents zero so stale storage never leaks out after reset.
            assign data_out  = empty ? '0 : mem[rd_ptr];
            assign valid_out = ~empty;
        end else begin : g_reg
            logic [WIDTH-1:0] dout_p1;
            logic             vld_p1;

            // ---- stage p1: registered read port ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_p1 <= '0;
                    vld_p1  <= 1'b0;
                end else if (enable) begin
                    if (flush) begin
                        vld_p1 <= 1'b0;
                    end else if (rd_acc) begin
                        dout_p1 <= mem[rd_ptr];
                        vld_p1  <= 1'b1;
                    end else begin
                        vld_p1 <= 1'b0;
                    end
                end
            end

            assign data_out  = dout_p1;
            assign valid_out = vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_npu_stream_fifo.sv
// Bench for npu_stream_fifo: a DEPTH=4 registered-output instance and a DEPTH=5
// FWFT instance share stimulus and are checked against queue-based models.
module tb_npu_stream_fifo;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       flush;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;

    logic [7:0] d_out [2];
    logic       d_vld [2];
    logic       d_full [2];
    logic       d_empty [2];
    logic       d_af [2];
    logic       d_ae [2];
    logic [2:0] d_cnt [2];
    logic       d_ovf [2];
    logic       d_udf [2];

    int checks   = 0;
    int failures = 0;

    npu_stream_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(d_out[0]), .valid_out(d_vld[0]), .full(d_full[0]),
        .empty(d_empty[0]), .almost_full(d_af[0]), .almost_empty(d_ae[0]),
        .count(d_cnt[0]), .overflow(d_ovf[0]), .underflow(d_udf[0])
    );

    npu_stream_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(d_out[1]), .valid_out(d_vld[1]), .full(d_full[1]),
        .empty(d_empty[1]), .almost_full(d_af[1]), .almost_empty(d_ae[1]),
        .count(d_cnt[1]), .overflow(d_ovf[1]), .underflow(d_udf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: one queue per instance plus sticky flags and the
    // registered read word for the non-FWFT instance.
    typedef logic [7:0] q_t [$];
    q_t         mq [2];
    int         m_depth [2] = '{4, 5};
    int         m_afth  [2] = '{3, 3};
    int         m_aeth  [2] = '{1, 1};
    logic       m_ovf [2]  = '{1'b0, 1'b0};
    logic       m_udf [2]  = '{1'b0, 1'b0};
    logic [7:0] m_dout     = 8'h00;
    logic       m_vld      = 1'b0;

    always @(posedge clk) begin
        int  n;
        bit  rd, wr;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                m_ovf[k] = 1'b0;
                m_udf[k] = 1'b0;
                if (k == 0) begin m_dout = 8'h00; m_vld = 1'b0; end
            end else if (enable && flush) begin
                mq[k].delete();
                m_ovf[k] = 1'b0;
                m_udf[k] = 1'b0;
                if (k == 0) m_vld = 1'b0;
            end else if (enable) begin
                n  = mq[k].size();
                rd = rd_en && (n > 0);
                wr = wr_en && ((n < m_depth[k]) || rd);
                if (rd_en && n == 0)                m_udf[k] = 1'b1;
                if (wr_en && n == m_depth[k] && !rd) m_ovf[k] = 1'b1;
                if (k == 0) m_vld = rd;
                if (rd) begin
                    if (k == 0) m_dout = mq[k].pop_front();
                    else        void'(mq[k].pop_front());
                end
                if (wr) mq[k].push_back(data_in);
            end
        end
    end

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        int n;
        for (int k = 0; k < 2; k++) begin
            n = mq[k].size();
            chk($sformatf("count[%0d]", k), 32'(d_cnt[k]), 32'(n));
            chk($sformatf("full[%0d]", k), 32'(d_full[k]), 32'(n == m_depth[k]));
            chk($sformatf("empty[%0d]", k), 32'(d_empty[k]), 32'(n == 0));
            chk($sformatf("almost_full[%0d]", k), 32'(d_af[k]), 32'(n >= m_afth[k]));
            chk($sformatf("almost_empty[%0d]", k), 32'(d_ae[k]), 32'(n <= m_aeth[k]));
            chk($sformatf("overflow[%0d]", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
            chk($sformatf("underflow[%0d]", k), 32'(d_udf[k]), 32'(m_udf[k]));
        end
        chk("valid_out[0]", 32'(d_vld[0]), 32'(m_vld));
        chk("data_out[0]", 32'(d_out[0]), 32'(m_dout));
        chk("valid_out[1]", 32'(d_vld[1]), 32'(mq[1].size() > 0));
        if (mq[1].size() > 0)
            chk("data_out[1]", 32'(d_out[1]), 32'(mq[1][0]));
    end

    // Apply one cycle of inputs; returns 1 time unit after the committing edge.
    task automatic drive(input logic r, input logic en, input logic fl,
                         input logic we, input logic re, input logic [7:0] d);
        rst = r; enable = en; flush = fl; wr_en = we; rd_en = re; data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rdexp [4];
        rdexp = '{8'h22, 8'h33, 8'h44, 8'h55};
        rst = 1'b1; enable = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        drive(1, 0, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 0, 8'h00);
        chk("rst empty", 32'(d_empty[0]), 32'd1);
        chk("rst count", 32'(d_cnt[0]), 32'd0);
        chk("rst valid", 32'(d_vld[0]), 32'd0);
        chk("rst dout", 32'(d_out[0]), 32'd0);
        chk("rst ae", 32'(d_ae[0]), 32'd1);
        chk("rst af", 32'(d_af[0]), 32'd0);

        drive(0, 1, 0, 1, 0, 8'h11);
        chk("wr1 empty", 32'(d_empty[0]), 32'd0);
        drive(0, 1, 0, 1, 0, 8'h22);
        drive(0, 1, 0, 1, 0, 8'h33);
        drive(0, 1, 0, 1, 0, 8'h44);
        chk("fill full", 32'(d_full[0]), 32'd1);
        chk("fill count", 32'(d_cnt[0]), 32'd4);
        chk("fill af", 32'(d_af[0]), 32'd1);

        drive(0, 1, 0, 1, 1, 8'h55);
        chk("wr+rd full count", 32'(d_cnt[0]), 32'd4);
        chk("wr+rd full ovf", 32'(d_ovf[0]), 32'd0);
        chk("wr+rd dout", 32'(d_out[0]), 32'h11);
        chk("wr+rd vld", 32'(d_vld[0]), 32'd1);
        drive(0, 1, 0, 1, 0, 8'h66);
        chk("ovf set", 32'(d_ovf[0]), 32'd1);
        chk("ovf count", 32'(d_cnt[0]), 32'd4);
        chk("b full", 32'(d_full[1]), 32'd1);
        drive(0, 1, 0, 0, 0, 8'h00);
        chk("ovf sticky", 32'(d_ovf[0]), 32'd1);

        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 1, 8'h00);
            chk($sformatf("rd%0d dout", i), 32'(d_out[0]), 32'(rdexp[i]));
            chk($sformatf("rd%0d vld", i), 32'(d_vld[0]), 32'd1);
        end
        drive(0, 1, 0, 0, 0, 8'h00);
        chk("drain vld", 32'(d_vld[0]), 32'd0);
        chk("drain empty", 32'(d_empty[0]), 32'd1);
        chk("b last word", 32'(d_out[1]), 32'h66);

        drive(0, 1, 0, 0, 1, 8'h00);
        chk("udf set", 32'(d_udf[0]), 32'd1);
        chk("udf vld", 32'(d_vld[0]), 32'd0);
        drive(0, 1, 1, 0, 0, 8'h00);
        chk("flush udf", 32'(d_udf[0]), 32'd0);
        chk("flush ovf", 32'(d_ovf[0]), 32'd0);

        drive(0, 1, 0, 1, 1, 8'h77);
        chk("rdwr empty count", 32'(d_cnt[0]), 32'd1);
        chk("rdwr empty udf", 32'(d_udf[0]), 32'd1);
        chk("b fwft 77", 32'(d_out[1]), 32'h77);
        drive(0, 1, 0, 0, 1, 8'h00);
        chk("rd after rdwr", 32'(d_out[0]), 32'h77);

        drive(0, 1, 0, 1, 0, 8'hA5);
        chk("fwft A5 data", 32'(d_out[1]), 32'hA5);
        chk("fwft A5 vld", 32'(d_vld[1]), 32'd1);
        drive(0, 1, 0, 0, 1, 8'h00);
        chk("fwft pop empty", 32'(d_empty[1]), 32'd1);

        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0, 8'(8'hC0 + i));
        chk("pre-flush count", 32'(d_cnt[0]), 32'd3);
        drive(0, 1, 1, 1, 0, 8'hEE);
        chk("flush+wr count", 32'(d_cnt[0]), 32'd0);
        chk("flush+wr empty", 32'(d_empty[0]), 32'd1);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0, 8'(8'hD0 + i));
        drive(0, 0, 0, 1, 0, 8'hEE);
        chk("en0 count", 32'(d_cnt[0]), 32'd3);
        drive(0, 1, 1, 0, 0, 8'h00);

        // Interleaved traffic through the depth-5 instance exercises pointer wrap.
        for (int i = 0; i < 12; i++) drive(0, 1, 0, 1, (i >= 2), 8'(i + 1));
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 1, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 2) != 0), 8'($urandom));
        end

        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 1, 8'(8'h90 + i));
        drive(1, 1, 0, 1, 1, 8'hFF);
        chk("midrst count", 32'(d_cnt[0]), 32'd0);
        chk("midrst empty", 32'(d_empty[0]), 32'd1);
        chk("midrst full", 32'(d_full[0]), 32'd0);
        chk("midrst vld", 32'(d_vld[0]), 32'd0);
        chk("midrst dout", 32'(d_out[0]), 32'd0);
        chk("midrst ovf", 32'(d_ovf[0]), 32'd0);
        chk("midrst udf", 32'(d_udf[0]), 32'd0);
        chk("midrst b vld", 32'(d_vld[1]), 32'd0);
        drive(0, 1, 0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
